// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding and legal WIDTH range for seq_mult_shift_add
package seq_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/seq_mult_shift_add_rca.sv
// rca_adder: N-bit ripple-carry adder built from full-adder cells
module rca_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[N];
endmodule

// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add: shift-and-add multiplier, WIDTH steps per product; SEQ_MULT_SIGNED_EN selects two's complement
module seq_mult_shift_add
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  localparam int CW = $clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_chk
    $error("seq_mult_shift_add: WIDTH out of range");
  end

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d, q_q, q_d;
  logic [WIDTH:0]   a_q, a_d, addend, sum;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last, cin, cout, msb_in;

  assign last = cnt_q == CW'(WIDTH - 1);

  rca_adder #(.N(WIDTH + 1)) u_add (
    .a(a_q), .b(addend), .cin(cin), .sum(sum), .cout(cout)
  );

  // adder operand select and the bit shifted into A's MSB
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    addend = q_q[0] ? (last ? ~{m_q[WIDTH-1], m_q} : {m_q[WIDTH-1], m_q}) : '0;
    cin    = q_q[0] & last;
    msb_in = a_q[WIDTH] ^ addend[WIDTH] ^ cout;
`else
    addend = q_q[0] ? {1'b0, m_q} : '0;
    cin    = 1'b0;
    msb_in = cout;
`endif
  end

  // next-state and datapath update
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        state_d = CALC;
        m_d     = in_a;
        q_d     = in_b;
        a_d     = '0;
        cnt_d   = '0;
      end
      CALC: begin
        a_d     = {msb_in, sum[WIDTH:1]};
        q_d     = {sum[0], q_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? DONE : CALC;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_p     = {a_q[WIDTH-1:0], q_q};
endmodule

// File: tb/tb_seq_mult_shift_add.sv
// tb_seq_mult_shift_add: scoreboard bench with randomized and directed operand pairs
module tb_seq_mult_shift_add;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [2*W-1:0] out_p;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [2*W-1:0] sb[$];
  int acc_q[$], pop_q[$];
  logic ov_prev = 0;

  always #5 clk = ~clk;

  seq_mult_shift_add #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
  );

  function automatic logic [2*W-1:0] model(logic [W-1:0] a, logic [W-1:0] b);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
  endfunction

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail(string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s", msg);
  endfunction

  // scoreboard push on every accepted operand pair; reset discards in-flight work
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      acc_q.delete();
    end else if (in_valid && in_ready) begin
      sb.push_back(model(in_a, in_b));
      acc_q.push_back(cyc);
    end
  end

  // monitor: latency on out_valid rise, product on handoff
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_prev) begin
      if (acc_q.size() == 0) fail("latency: out_valid rose with no accepted op");
      else check("latency", cyc - acc_q.pop_front(), W);
    end
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) fail($sformatf("product: unexpected result 0x%0h, expected none", out_p));
      else check("product", {16'h0, out_p}, {16'h0, sb.pop_front()});
      pop_q.push_back(cyc);
    end
    ov_prev = out_valid;
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready) begin
      if (++t > 100) begin
        fail("ready_timeout: in_ready stayed 0, expected 1");
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
    wait_ready();
    in_valid = 1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain(bit rnd);
    int t = 0;
    while (sb.size() != 0 || !in_ready) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (++t > 300) begin
        fail("drain_timeout: results outstanding, expected none");
        break;
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] va[$], vb[$];
    logic [2*W-1:0] exp;
    int t, seen, base;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_p", out_p, 0);
    rst_n = 1;
`ifdef SEQ_MULT_SIGNED_EN
    va = '{8'hFD, 8'h80, 8'h7F};
    vb = '{8'h05, 8'h80, 8'hFF};
`else
    va = '{8'd13, 8'hFF, 8'h00, 8'hFD};
    vb = '{8'd11, 8'hFF, 8'hA5, 8'h05};
`endif
    foreach (va[i]) begin
      issue(va[i], vb[i]);
      drain(0);
    end
    out_ready = 0;
    issue(8'h9C, 8'h37);
    exp = model(8'h9C, 8'h37);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) fail("bp_timeout: out_valid stayed 0, expected 1");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_p", {16'h0, out_p}, {16'h0, exp});
      check("bp_in_ready", in_ready, 0);
      if (i == 1) begin
        in_valid = 1;
        in_a = 8'h11;
        in_b = 8'h22;
      end
      if (i == 2) in_valid = 0;
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1;
    seen = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_no_latch", seen, 1);
    drain(0);
    issue(8'h55, 8'h77);
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    rst_n = 1;
    issue(8'd3, 8'd7);
    drain(0);
    base = pop_q.size();
    wait_ready();
    in_valid = 1;
    in_a = 8'd2;
    in_b = 8'd3;
    @(posedge clk);
    #1;
    in_a = 8'd200;
    in_b = 8'd2;
    wait_ready();
    @(posedge clk);
    #1 in_valid = 0;
    drain(0);
    if (pop_q.size() >= base + 2) check("b2b_spacing", pop_q[base+1] - pop_q[base], W + 2);
    else fail("b2b: fewer than two results seen");
    repeat (25) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(W'($urandom), W'($urandom));
      drain(1);
    end
    check("queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
